// File: rtl/fl_skid_stats.sv
// FrameLink output stage: 2-entry skid buffer with a fully registered TX side,
// TX frame/byte statistics and sticky RX protocol error flags.
module fl_skid_stats #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DREM_WIDTH = 3,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic [DREM_WIDTH-1:0] rx_rem,
    input  logic                  rx_sof_n,
    input  logic                  rx_eof_n,
    input  logic                  rx_sop_n,
    input  logic                  rx_eop_n,
    input  logic                  rx_src_rdy_n,
    output logic                  rx_dst_rdy_n,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [DREM_WIDTH-1:0] tx_rem,
    output logic                  tx_sof_n,
    output logic                  tx_eof_n,
    output logic                  tx_sop_n,
    output logic                  tx_eop_n,
    output logic                  tx_src_rdy_n,
    input  logic                  tx_dst_rdy_n,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [CNT_WIDTH-1:0]  byte_cnt,
    output logic [2:0]            err
);

    localparam int unsigned WordW = DATA_WIDTH + DREM_WIDTH + 4;
    // Idle word: zero data/rem, all active-low controls deasserted.
    localparam logic [WordW-1:0] WordRst = {{(DATA_WIDTH + DREM_WIDTH){1'b0}}, 4'hf};

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e               state_q, state_d;
    logic [WordW-1:0]     main_q, main_d;
    logic [WordW-1:0]     skid_q, skid_d;
    logic                 rx_busy_q;
    logic                 in_frame_q, in_frame_d;
    logic [CNT_WIDTH-1:0] frame_q, frame_d;
    logic [CNT_WIDTH-1:0] byte_q, byte_d;
    logic [CNT_WIDTH-1:0] byte_add;
    logic [2:0]           err_q, err_d, err_new;
    logic [WordW-1:0]     rx_word;
    logic                 rx_xfer, tx_xfer;

    assign rx_word = {rx_data, rx_rem, rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n};
    assign rx_xfer = ~rx_src_rdy_n & ~rx_busy_q;
    assign tx_xfer = (state_q != StEmpty) & ~tx_dst_rdy_n;

    assign {tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n} = main_q;
    assign tx_src_rdy_n = (state_q == StEmpty);
    assign rx_dst_rdy_n = rx_busy_q;
    assign frame_cnt    = frame_q;
    assign byte_cnt     = byte_q;
    assign err          = err_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (rx_xfer) begin
                    main_d  = rx_word;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (rx_xfer && tx_xfer) begin
                    main_d = rx_word;
                end else if (rx_xfer) begin
                    skid_d  = rx_word;
                    state_d = StTwo;
                end else if (tx_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (tx_xfer) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // A clear in the same cycle as an increment leaves just the increment.
    always_comb begin
        byte_add = '0;
        if (tx_xfer) begin
            byte_add = tx_eop_n ? CNT_WIDTH'(DATA_WIDTH / 8)
                                : CNT_WIDTH'(tx_rem) + CNT_WIDTH'(1);
        end
        frame_d = (cnt_clear ? '0 : frame_q) + CNT_WIDTH'(tx_xfer & ~tx_eof_n);
        byte_d  = (cnt_clear ? '0 : byte_q) + byte_add;
    end

    always_comb begin
        err_new    = 3'b000;
        in_frame_d = in_frame_q;
        if (rx_xfer) begin
            err_new = {~rx_eof_n & rx_eop_n, rx_sof_n & ~in_frame_q, ~rx_sof_n & in_frame_q};
            if (!rx_eof_n) begin
                in_frame_d = 1'b0;
            end else if (!rx_sof_n) begin
                in_frame_d = 1'b1;
            end
        end
        err_d = (cnt_clear ? 3'b000 : err_q) | err_new;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StEmpty;
            main_q     <= WordRst;
            skid_q     <= WordRst;
            rx_busy_q  <= 1'b1;
            in_frame_q <= 1'b0;
            frame_q    <= '0;
            byte_q     <= '0;
            err_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            rx_busy_q  <= (state_d == StTwo);
            in_frame_q <= in_frame_d;
            frame_q    <= frame_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_fl_skid_stats.sv
// Self-checking bench for fl_skid_stats: scoreboard of RX words against TX words plus
// a reference model of the counters and error flags; a CNT_WIDTH=4 copy checks wrap.
module tb_fl_skid_stats;

    localparam int unsigned DW = 64;
    typedef logic [DW+7-1:0] word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic [2:0]    rx_rem;
    logic          rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n, rx_dst_rdy_n;
    logic [DW-1:0] tx_data;
    logic [2:0]    tx_rem;
    logic          tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n, tx_dst_rdy_n;
    logic          cnt_clear;
    logic [31:0]   frame_cnt, byte_cnt;
    logic [2:0]    err;

    logic          rx_dst_rdy_n4, tx_src_rdy_n4;
    logic [DW-1:0] tx_data4;
    logic [2:0]    tx_rem4, err4;
    logic          tx_sof_n4, tx_eof_n4, tx_sop_n4, tx_eop_n4;
    logic [3:0]    frame_cnt4, byte_cnt4;

    word_t rx_word, tx_word;
    assign rx_word = {rx_data, rx_rem, rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n};
    assign tx_word = {tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n};

    always #5 clk = ~clk;

    fl_skid_stats #(.DATA_WIDTH(DW), .DREM_WIDTH(3), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_rem(rx_rem), .rx_sof_n(rx_sof_n), .rx_eof_n(rx_eof_n),
        .rx_sop_n(rx_sop_n), .rx_eop_n(rx_eop_n), .rx_src_rdy_n(rx_src_rdy_n),
        .rx_dst_rdy_n(rx_dst_rdy_n),
        .tx_data(tx_data), .tx_rem(tx_rem), .tx_sof_n(tx_sof_n), .tx_eof_n(tx_eof_n),
        .tx_sop_n(tx_sop_n), .tx_eop_n(tx_eop_n), .tx_src_rdy_n(tx_src_rdy_n),
        .tx_dst_rdy_n(tx_dst_rdy_n),
        .cnt_clear(cnt_clear), .frame_cnt(frame_cnt), .byte_cnt(byte_cnt), .err(err)
    );

    fl_skid_stats #(.DATA_WIDTH(DW), .DREM_WIDTH(3), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_rem(rx_rem), .rx_sof_n(rx_sof_n), .rx_eof_n(rx_eof_n),
        .rx_sop_n(rx_sop_n), .rx_eop_n(rx_eop_n), .rx_src_rdy_n(rx_src_rdy_n),
        .rx_dst_rdy_n(rx_dst_rdy_n4),
        .tx_data(tx_data4), .tx_rem(tx_rem4), .tx_sof_n(tx_sof_n4), .tx_eof_n(tx_eof_n4),
        .tx_sop_n(tx_sop_n4), .tx_eop_n(tx_eop_n4), .tx_src_rdy_n(tx_src_rdy_n4),
        .tx_dst_rdy_n(tx_dst_rdy_n),
        .cnt_clear(cnt_clear), .frame_cnt(frame_cnt4), .byte_cnt(byte_cnt4), .err(err4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and reference model, sampled on the falling edge.
    word_t       sb[$];
    word_t       w;
    logic [31:0] exp_frame, exp_byte, finc, badd;
    logic [2:0]  exp_err, enew;
    logic        exp_in, skip_rdy;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            sb.delete();
            exp_frame = '0;
            exp_byte  = '0;
            exp_err   = '0;
            exp_in    = 1'b0;
            skip_rdy  = 1'b1;
            check_eq("rst_tx_vld", tx_src_rdy_n, 1);
            check_eq("rst_rx_rdy", rx_dst_rdy_n, 1);
            check_eq("rst_frame", frame_cnt, 0);
            check_eq("rst_bytes", byte_cnt, 0);
            check_eq("rst_err", err, 0);
        end else begin
            check_eq("tx_vld", !tx_src_rdy_n, sb.size() != 0);
            if (skip_rdy) skip_rdy = 1'b0;
            else check_eq("rx_rdy", !rx_dst_rdy_n, sb.size() < 2);
            check_eq("frame_cnt", frame_cnt, exp_frame);
            check_eq("frame_cnt4", frame_cnt4, exp_frame[3:0]);
            check_eq("byte_cnt", byte_cnt, exp_byte);
            check_eq("err", err, exp_err);
            finc = '0;
            badd = '0;
            enew = '0;
            if (!tx_src_rdy_n && !tx_dst_rdy_n) begin
                check_eq("tx_pop", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    w = sb.pop_front();
                    check_eq("tx_word", tx_word, w);
                    finc = {31'd0, !w[2]};
                    badd = w[0] ? 32'd8 : 32'(w[6:4]) + 32'd1;
                end
            end
            if (!rx_src_rdy_n && !rx_dst_rdy_n) begin
                sb.push_back(rx_word);
                enew = {!rx_eof_n && rx_eop_n, rx_sof_n && !exp_in, !rx_sof_n && exp_in};
                if (!rx_eof_n) exp_in = 1'b0;
                else if (!rx_sof_n) exp_in = 1'b1;
            end
            exp_frame = (cnt_clear ? 32'd0 : exp_frame) + finc;
            exp_byte  = (cnt_clear ? 32'd0 : exp_byte) + badd;
            exp_err   = (cnt_clear ? 3'b000 : exp_err) | enew;
        end
    end

    // 0: always ready, 1: held busy, 2: random backpressure
    int tx_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (tx_mode)
            0:       tx_dst_rdy_n = 1'b0;
            1:       tx_dst_rdy_n = 1'b1;
            default: tx_dst_rdy_n = ($urandom_range(7) == 0);
        endcase
    end

    task automatic send_word(input logic [DW-1:0] d, input logic [2:0] r,
                             input logic sof, input logic eof, input logic sop, input logic eop);
        bit acc = 1'b0;
        rx_data      = d;
        rx_rem       = r;
        rx_sof_n     = !sof;
        rx_eof_n     = !eof;
        rx_sop_n     = !sop;
        rx_eop_n     = !eop;
        rx_src_rdy_n = 1'b0;
        for (int n = 0; n < 500 && !acc; n++) begin
            @(negedge clk);
            acc = !rx_dst_rdy_n;
            @(posedge clk);
            #1;
        end
        rx_src_rdy_n = 1'b1;
        check_eq("rx_accept", acc, 1);
    endtask

    task automatic send_frame(input int len, input logic [2:0] last_rem, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(15) == 0) begin
                @(posedge clk);
                #1;
            end
            send_word({$urandom, $urandom}, (i == len - 1) ? last_rem : 3'($urandom_range(7)),
                      i == 0, i == len - 1, i == 0, i == len - 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(sb.size() == 0 && tx_src_rdy_n) && n < 2000);
        check_eq("drain", sb.size() == 0 && tx_src_rdy_n, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    longint unsigned sum;
    int              len;
    logic [2:0]      r;

    initial begin
        reset        = 1'b1;
        rx_data      = '0;
        rx_rem       = '0;
        rx_sof_n     = 1'b1;
        rx_eof_n     = 1'b1;
        rx_sop_n     = 1'b1;
        rx_eop_n     = 1'b1;
        rx_src_rdy_n = 1'b1;
        tx_dst_rdy_n = 1'b0;
        cnt_clear    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 3-word frame, 8+8+6 bytes
        send_frame(3, 3'd5, 1'b0);
        drain();
        check_eq("t1_frame", frame_cnt, 1);
        check_eq("t1_bytes", byte_cnt, 22);
        check_eq("t1_err", err, 0);

        // backpressure: only two words fit, then RX stalls
        tx_mode = 1;
        fork
            send_frame(5, 3'd7, 1'b0);
            begin
                repeat (8) @(negedge clk);
                #1;
                check_eq("t2_held", sb.size(), 2);
                check_eq("t2_rx_stall", rx_dst_rdy_n, 1);
                check_eq("t2_tx_vld", tx_src_rdy_n, 0);
                tx_mode = 0;
            end
        join
        drain();
        check_eq("t2_frame", frame_cnt, 2);
        check_eq("t2_bytes", byte_cnt, 22 + 40);

        // random traffic
        pulse_clear();
        tx_mode = 2;
        sum = 0;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(64, 1);
            r   = 3'($urandom_range(7));
            send_frame(len, r, 1'b1);
            sum += 64'(len - 1) * 8 + 64'(r) + 1;
        end
        tx_mode = 0;
        drain();
        check_eq("t3_frame", frame_cnt, 1000);
        check_eq("t3_bytes", byte_cnt, sum);
        check_eq("t3_err", err, 0);

        // SOF inside an open frame
        pulse_clear();
        send_word(64'h1, 3'd0, 1, 0, 1, 0);
        send_word(64'h2, 3'd0, 1, 0, 1, 0);
        send_word(64'h3, 3'd4, 0, 1, 0, 1);
        drain();
        check_eq("t4_err_sof", err, 3'b001);
        pulse_clear();
        check_eq("t4_clr_err", err, 0);
        check_eq("t4_clr_frame", frame_cnt, 0);
        check_eq("t4_clr_bytes", byte_cnt, 0);
        // EOF without EOP
        send_word(64'h4, 3'd2, 1, 1, 1, 0);
        drain();
        check_eq("t4_err_eop", err, 3'b100);
        check_eq("t4_bytes", byte_cnt, 8);

        // counter wrap and clear colliding with an increment
        pulse_clear();
        for (int i = 0; i < 17; i++) send_word(64'(i), 3'd0, 1, 1, 1, 1);
        drain();
        check_eq("t5_wrap4", frame_cnt4, 1);
        check_eq("t5_frame32", frame_cnt, 17);
        send_word(64'hbeef, 3'd3, 1, 1, 1, 1);
        pulse_clear();
        check_eq("t5_clr_inc", frame_cnt, 1);
        check_eq("t5_clr_inc4", frame_cnt4, 1);
        check_eq("t5_clr_bytes", byte_cnt, 4);

        // reset with two words buffered mid-frame
        tx_mode = 1;
        send_word(64'haa, 3'd0, 1, 0, 1, 0);
        send_word(64'hbb, 3'd0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t6_rst_tx", tx_src_rdy_n, 1);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        tx_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("t6_no_stale", tx_src_rdy_n, 1);
        send_frame(4, 3'd6, 1'b0);
        drain();
        check_eq("t6_err", err, 0);
        check_eq("t6_frame", frame_cnt, 1);
        check_eq("t6_bytes", byte_cnt, 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
